// File: rtl/uart_pkg.sv
// Shared UART definitions: line idle level and the bit-level FSM state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

  // Level of the serial line between frames (also the stop-bit level).
  localparam logic UART_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/axis_byte_fifo.sv
// Small synchronous FIFO for received bytes plus their tlast flag.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axis_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer advance on accepted push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART 8N1 receiver presenting bytes as an AXI-Stream master.
// A burst of back-to-back bytes becomes one packet; tlast is attached once the
// line has stayed idle long enough after the last byte.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | line idle, waiting for a low level on rx_s
//  START | half a bit-time in; a high sample means it was a glitch
//  DATA  | sampling DATA_BITS data bits at bit centres, LSB first
//  STOP  | sampling the stop bit; high = good byte, low = framing error
module uart_rx_axis #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_BITS    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 frame_err,
  output logic                 overrun
);

  import uart_pkg::*;

  localparam int TMR_W      = $clog2(CLKS_PER_BIT);
  localparam int IDX_W      = $clog2(DATA_BITS + 1);
  localparam int IDLE_TICKS = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_TICKS + 1);

  localparam logic [TMR_W-1:0]  HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0]  BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TICKS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_t          state;
  logic [TMR_W-1:0]     tmr;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 byte_stb;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_valid;
  logic                 idle_expire;
  logic                 push_req;
  logic [DATA_BITS:0]   push_word;
  logic                 pop;
  logic [DATA_BITS:0]   head_word;
  logic                 fifo_empty;
  logic                 fifo_full;

  // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= UART_IDLE;
      rx_s    <= UART_IDLE;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Bit-level receive FSM with a down-counting bit timer; byte_stb and frame_err are 1-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s != UART_IDLE) begin
            state   <= START;
            tmr     <= HALF_LOAD;
            bit_idx <= '0;
          end
        end
        START: begin
          if (tmr == '0) begin
            if (rx_s == UART_IDLE) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              tmr   <= BIT_LOAD;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DATA: begin
          if (tmr == '0) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            tmr   <= BIT_LOAD;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        STOP: begin
          if (tmr == '0) begin
            // Returning at mid-stop leaves half a bit to catch the next start edge.
            state <= IDLE;
            if (rx_s == UART_IDLE) begin
              byte_stb <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Idle timer: reloads whenever the FSM leaves IDLE, counts down and holds at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= IDLE_LOAD;
    end else if (state != IDLE) begin
      idle_cnt <= IDLE_LOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  assign idle_expire = pend_valid && (state == IDLE) && (idle_cnt == '0);

  // The pending byte is held back until we know whether another byte follows it.
  // A new byte pushes the old one with tlast=0; idle timeout pushes it with tlast=1.
  assign push_req  = (byte_stb && pend_valid) || idle_expire;
  assign push_word = {!byte_stb, pend_data};

  // Pending register: last good byte whose tlast is not yet known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_valid <= 1'b0;
    end else if (byte_stb) begin
      pend_data  <= shreg;
      pend_valid <= 1'b1;
    end else if (idle_expire) begin
      pend_valid <= 1'b0;
    end
  end

  assign pop = m_axis_tvalid && m_axis_tready;

  // Overrun pulse: a push attempt the FIFO could not take (full with no pop this cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push_req && fifo_full && !pop;
    end
  end

  axis_byte_fifo #(
    .WIDTH(DATA_BITS + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push_req),
    .wr_data(push_word),
    .rd_en  (pop),
    .rd_data(head_word),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = head_word[DATA_BITS-1:0];
  assign m_axis_tlast  = head_word[DATA_BITS];

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis with CLKS_PER_BIT=16, IDLE_BITS=10, FIFO_DEPTH=4.
module tb_uart_rx_axis;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic       frame_err;
  logic       overrun;

  int errs = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [8:0] beats [$];

  uart_rx_axis #(
    .DATA_BITS(8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4),
    .IDLE_BITS(10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: accepted beats and flag pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      wait_cycles(CPB);
    end
    uart_rx = stop_bit;
    wait_cycles(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [8:0] exp);
    logic [8:0] v;
    v = (idx < beats.size()) ? beats[idx] : 9'h000;
    chk(tag, {23'b0, v}, {23'b0, exp});
  endtask

  task automatic clear_obs();
    beats.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  initial begin
    int n;
    logic [7:0] d3c;

    // Reset values
    wait_cycles(3);
    chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", {24'b0, m_axis_tdata}, 32'd0);
    chk("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Single 0xA5, tready=1; tvalid roughly ten bit-times after frame end
    m_axis_tready = 1'b1;
    clear_obs();
    send_frame(8'hA5, 1'b1);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (m_axis_tvalid) break;
      n++;
    end
    wait_cycles(5);
    chk("a5_latency_window", {31'b0, (n >= 150 && n <= 165)}, 32'd1);
    chk("a5_count", beats.size(), 32'd1);
    chk_beat("a5_beat", 0, {1'b1, 8'hA5});

    // Back-to-back burst 01,02,03
    clear_obs();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    wait_cycles(400);
    chk("burst_count", beats.size(), 32'd3);
    chk_beat("burst_b0", 0, {1'b0, 8'h01});
    chk_beat("burst_b1", 1, {1'b0, 8'h02});
    chk_beat("burst_b2", 2, {1'b1, 8'h03});
    chk("burst_fe", fe_cnt, 32'd0);
    chk("burst_ov", ov_cnt, 32'd0);

    // Stop bit low on 0x55, then a clean 0x66
    clear_obs();
    send_frame(8'h55, 1'b0);
    wait_cycles(60);
    chk("ferr_pulses", fe_cnt, 32'd1);
    chk("ferr_no_beat", beats.size(), 32'd0);
    send_frame(8'h66, 1'b1);
    wait_cycles(400);
    chk("after_ferr_count", beats.size(), 32'd1);
    chk_beat("after_ferr_beat", 0, {1'b1, 8'h66});

    // Short low glitch on the idle line
    clear_obs();
    uart_rx = 1'b0;
    wait_cycles(6);
    uart_rx = 1'b1;
    wait_cycles(400);
    chk("glitch_no_beat", beats.size(), 32'd0);
    chk("glitch_fe", fe_cnt, 32'd0);
    chk("glitch_ov", ov_cnt, 32'd0);

    // tready=0, six bytes: FIFO fills with 4, 5th byte lost, 6th pending
    clear_obs();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_frame(8'h10 + 8'(i), 1'b1);
    wait_cycles(20);
    chk("ovr_pulses", ov_cnt, 32'd1);
    chk("ovr_tvalid_held", {31'b0, m_axis_tvalid}, 32'd1);
    chk("ovr_head_stable", {23'b0, m_axis_tlast, m_axis_tdata}, {23'b0, 1'b0, 8'h10});
    m_axis_tready = 1'b1;
    wait_cycles(400);
    chk("ovr_drain_count", beats.size(), 32'd5);
    chk_beat("ovr_b0", 0, {1'b0, 8'h10});
    chk_beat("ovr_b1", 1, {1'b0, 8'h11});
    chk_beat("ovr_b2", 2, {1'b0, 8'h12});
    chk_beat("ovr_b3", 3, {1'b0, 8'h13});
    chk_beat("ovr_b4", 4, {1'b1, 8'h15});
    chk("ovr_pulses_final", ov_cnt, 32'd1);

    // Reset mid-frame with a beat waiting in the FIFO
    clear_obs();
    m_axis_tready = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_cycles(200);
    chk("prerst_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
    chk("prerst_tdata", {24'b0, m_axis_tdata}, 32'h11);
    d3c = 8'h3C;
    uart_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = d3c[i];
      wait_cycles(CPB);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("midrst_tdata", {24'b0, m_axis_tdata}, 32'd0);
    chk("midrst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    uart_rx = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    clear_obs();
    wait_cycles(5);
    send_frame(8'h7E, 1'b1);
    wait_cycles(400);
    chk("postrst_count", beats.size(), 32'd1);
    chk_beat("postrst_beat", 0, {1'b1, 8'h7E});
    chk("postrst_flags", fe_cnt + ov_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
